// File: rtl/pc_lut_alloc.sv
// rtl/pc_lut_alloc.sv - branch-target allocator: encodes a target into a LUT index, allocating on a miss
// Optional flush port is enabled by defining PC_LUT_ALLOC_FLUSH_EN.
module pc_lut_alloc #(
   parameter  int D     = 10,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef PC_LUT_ALLOC_FLUSH_EN
   input  logic          flush,
`endif
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [D-1:0]  req_target,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [AW-1:0] resp_index,
   output logic          resp_hit,
   output logic          resp_full,
   output logic [AW:0]   count,
   input  logic [AW-1:0] rd_addr,
   output logic [D-1:0]  rd_data
);

   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEARCH, ALLOC, RESP} state_t;

   state_t        state_q;
   logic [D-1:0]  entry_q [DEPTH];
   logic [D-1:0]  tgt_q;
   logic [AW-1:0] ptr_q;
   logic [AW:0]   count_q;
   logic          req_ready_q;
   logic          resp_valid_q;
   logic [AW-1:0] resp_index_q;
   logic          resp_hit_q;
   logic          resp_full_q;
   logic [D-1:0]  rd_data_q;

   logic flush_d;
   logic accept_d;
   logic last_d;
   logic full_d;
   logic rd_in_range_d;

`ifdef PC_LUT_ALLOC_FLUSH_EN
   assign flush_d = flush & (state_q == IDLE);
`else
   assign flush_d = 1'b0;
`endif

   // A flush cycle masks req_ready so a simultaneous request is not taken.
   assign req_ready     = req_ready_q & ~flush_d;
   assign accept_d      = req_valid & req_ready;
   assign last_d        = ({1'b0, ptr_q} == (count_q - CNT_ONE));
   assign full_d        = (count_q == CNT_FULL);
   assign rd_in_range_d = ({1'b0, rd_addr} < count_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         tgt_q        <= '0;
         ptr_q        <= '0;
         count_q      <= CNT_ONE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_index_q <= '0;
         resp_hit_q   <= 1'b0;
         resp_full_q  <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         rd_data_q <= rd_in_range_d ? entry_q[rd_addr] : '0;
         case (state_q)
            IDLE: begin
               if (flush_d) begin
                  for (int i = 1; i < DEPTH; i++) entry_q[i] <= '0;
                  count_q <= CNT_ONE;
               end else if (accept_d) begin
                  tgt_q       <= req_target;
                  ptr_q       <= '0;
                  req_ready_q <= 1'b0;
                  state_q     <= SEARCH;
               end
            end
            SEARCH: begin
               if (entry_q[ptr_q] == tgt_q) begin
                  resp_index_q <= ptr_q;
                  resp_hit_q   <= 1'b1;
                  resp_full_q  <= 1'b0;
                  state_q      <= RESP;
               end else if (last_d && !full_d) begin
                  state_q <= ALLOC;
               end else if (last_d) begin
                  resp_index_q <= '0;
                  resp_hit_q   <= 1'b0;
                  resp_full_q  <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            ALLOC: begin
               // count never equals DEPTH here, so its low bits address the new slot.
               entry_q[count_q[AW-1:0]] <= tgt_q;
               resp_index_q             <= count_q[AW-1:0];
               resp_hit_q               <= 1'b0;
               resp_full_q              <= 1'b0;
               count_q                  <= count_q + CNT_ONE;
               state_q                  <= RESP;
            end
            RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_index = resp_index_q;
   assign resp_hit   = resp_hit_q;
   assign resp_full  = resp_full_q;
   assign count      = count_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_pc_lut_alloc.sv
// tb/tb_pc_lut_alloc.sv - directed self-checking bench for pc_lut_alloc
module tb_pc_lut_alloc;
   localparam int D     = 10;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          resp_ready = 1'b0;
   logic [D-1:0]  req_target = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          req_ready, resp_valid, resp_hit, resp_full;
   logic [AW-1:0] resp_index;
   logic [AW:0]   count;
   logic [D-1:0]  rd_data;
`ifdef PC_LUT_ALLOC_FLUSH_EN
   logic          flush = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_lut_alloc #(.D(D), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef PC_LUT_ALLOC_FLUSH_EN
      .flush     (flush),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_target(req_target),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_index(resp_index),
      .resp_hit  (resp_hit),
      .resp_full (resp_full),
      .count     (count),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic read_chk(input string tag, input logic [AW-1:0] addr, input int exp);
      @(negedge clk);
      rd_addr = addr;
      @(posedge clk);
      @(negedge clk);
      chk(tag, 32'(rd_data), exp);
   endtask

   // Issue one request, measure accept-to-resp_valid latency, optionally stall the consumer.
   task automatic do_req(input string tag, input int tgt, input int hold, input int exp_lat,
                         input int exp_idx, input int exp_hit, input int exp_full, input int exp_cnt);
      int cyc;
      @(negedge clk);
      chk({tag, " req_ready_idle"}, 32'(req_ready), 1);
      req_valid = 1'b1; req_target = D'(tgt);
      @(posedge clk);
      cyc = 0;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, " req_ready_busy"}, 32'(req_ready), 0);
      while (!resp_valid && cyc < 40) begin
         @(posedge clk); cyc++; @(negedge clk);
      end
      chk({tag, " latency"}, 32'(cyc), exp_lat);
      chk({tag, " index"}, 32'(resp_index), exp_idx);
      chk({tag, " hit"}, 32'(resp_hit), exp_hit);
      chk({tag, " full"}, 32'(resp_full), exp_full);
      chk({tag, " count"}, 32'(count), exp_cnt);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         chk({tag, " hold_valid"}, 32'(resp_valid), 1);
         chk({tag, " hold_index"}, 32'(resp_index), exp_idx);
         chk({tag, " hold_hit"}, 32'(resp_hit), exp_hit);
         chk({tag, " hold_req_ready"}, 32'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, " valid_drop"}, 32'(resp_valid), 0);
      chk({tag, " back_idle"}, 32'(req_ready), 1);
      chk({tag, " index_held"}, 32'(resp_index), exp_idx);
   endtask

   initial begin
      do_reset();
      chk("rst count", 32'(count), 1);
      chk("rst req_ready", 32'(req_ready), 1);
      chk("rst resp_valid", 32'(resp_valid), 0);
      chk("rst resp_hit", 32'(resp_hit), 0);
      chk("rst resp_full", 32'(resp_full), 0);
      chk("rst resp_index", 32'(resp_index), 0);
      chk("rst rd_data", 32'(rd_data), 0);

      do_req("t1 zero", 0, 0, 2, 0, 1, 0, 1);

      do_req("t2 10", 10, 0, 3, 1, 0, 0, 2);
      do_req("t2 41", 41, 0, 4, 2, 0, 0, 3);
      do_req("t2 10again", 10, 0, 3, 1, 1, 0, 3);
      read_chk("t2 rd2", 4'd2, 41);
      read_chk("t2 rd3_oob", 4'd3, 0);

      do_reset();
      for (int i = 1; i <= 15; i++) do_req("t3 alloc", i, 0, i + 2, i, 0, 0, i + 1);
      do_req("t3 full", 99, 0, 17, 0, 0, 1, 16);
      do_req("t3 last_hit", 15, 0, 17, 15, 1, 0, 16);
      read_chk("t3 rd15", 4'd15, 15);

      do_req("t4 stall", 5, 5, 7, 5, 1, 0, 16);

      do_reset();
      do_req("t5 20", 20, 0, 3, 1, 0, 0, 2);
      do_req("t5 30", 30, 0, 4, 2, 0, 0, 3);
      do_req("t5 40", 40, 0, 5, 3, 0, 0, 4);
      read_chk("t5 rd1_pre", 4'd1, 20);
      @(negedge clk);
      req_valid = 1'b1; req_target = D'(50);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5 searching", 32'(req_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("t5 rst count", 32'(count), 1);
      chk("t5 rst resp_valid", 32'(resp_valid), 0);
      chk("t5 rst req_ready", 32'(req_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      read_chk("t5 rd1_post", 4'd1, 0);

`ifdef PC_LUT_ALLOC_FLUSH_EN
      do_reset();
      do_req("t6 72", 72, 0, 3, 1, 0, 0, 2);
      do_req("t6 87", 87, 0, 4, 2, 0, 0, 3);
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_target = D'(87);
      #1;
      chk("t6 flush req_ready", 32'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      chk("t6 flush count", 32'(count), 1);
      chk("t6 flush not_taken", 32'(req_ready), 1);
      do_req("t6 87 realloc", 87, 0, 3, 1, 0, 0, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_lut_alloc.md
Name: pc_lut_alloc

Overview:
Branch-target allocator: the encoder side of the 16-entry, 10-bit PC branch-target lookup table. Given an absolute branch target, it returns the 4-bit LUT index that selects it, allocating a new entry on a miss. It is used by the program loader and assembler-side hardware to build the target table. A read port dumps the table so it can be loaded into the fetch-stage LUT.

Parameters:
D, 10, target/PC width in bits
DEPTH, 16, number of table entries; index width AW = $clog2(DEPTH) (localparam, 4 at default)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  lookup/allocate request valid
req_ready  output  1  block can accept a request
req_target  input  D  branch target to encode
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_index  output  AW  LUT index holding req_target
resp_hit  output  1  target already present
resp_full  output  1  miss with table full; resp_index invalid (0)
count  output  AW+1  number of valid entries (1..DEPTH)
rd_addr  input  AW  table dump address
rd_data  output  D  entry[rd_addr], registered

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - all entries = 0; entry 0 is permanently target 0; count = 1
  - state = IDLE; req_ready = 1
  - resp_valid, resp_hit, resp_full, resp_index, rd_data = 0
- Table state: entries 0..count-1 valid; entries are never removed except by reset or the optional flush.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_target into tgt, set ptr = 0, go to SEARCH.
  - req_ready drops the cycle after acceptance; one request is outstanding at a time.
- SEARCH (one entry compared per cycle):
  - entry[ptr] == tgt: resp_index = ptr, resp_hit = 1, resp_full = 0; go to RESP.
  - Else if ptr == count-1 and count < DEPTH: go to ALLOC.
  - Else if ptr == count-1 and count == DEPTH: resp_full = 1, resp_hit = 0, resp_index = 0; go to RESP.
  - Else: ptr++.
- ALLOC: entry[count] = tgt; resp_index = count; resp_hit = 0; count++; go to RESP.
- RESP:
  - resp_valid = 1; resp_* are stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid = 0, go to IDLE.
  - resp_* hold their last value after the handshake.
- Latency, accept edge = cycle 0:
  - hit at index k: resp_valid high from cycle k+2
  - miss with table not full: resp_valid high from cycle count+2 (count before allocation)
  - miss with table full: resp_valid high from cycle DEPTH+1
- Duplicates: first match wins. The allocator never creates duplicates, so first match = only match.
- Width: target compare is full D-bit equality. count is AW+1 bits and reaches DEPTH exactly, with no wrap. ptr never exceeds count-1.
- Read port:
  - rd_data <= (rd_addr < count) ? entry[rd_addr] : 0, one-cycle latency.
  - Reads are independent of state. An entry written in ALLOC is visible on rd_data from the cycle after the write edge.
- Reset mid-operation: immediate return to the reset values; any in-flight request and response are dropped.
- req_valid while not IDLE: ignored (req_ready = 0). The requester holds its request.

Optional Feature:
PC_LUT_ALLOC_FLUSH_EN
- Defined: adds input port flush (1 bit).
  - In IDLE, flush = 1 clears entries 1..DEPTH-1 to 0 and sets count = 1 at the next edge.
  - In that cycle req_ready = 0, so flush wins over a simultaneous req_valid.
  - Outside IDLE, flush is ignored and not remembered.
- Undefined: no flush port; the table is only cleared by rst_n.

Test Plan:
1. After reset, request target 0 -> resp_hit = 1, resp_index = 0, resp_valid at cycle 2, count stays 1.
2. Request 10, then 41, then 10 -> responses:
   - 10: index 1, hit = 0, count = 2
   - 41: index 2, hit = 0, count = 3
   - 10 again: index 1, hit = 1, resp_valid at cycle 3
3. Allocate 15 distinct targets 1..15, then request 99 -> final count = 16; the 99 response has resp_full = 1, resp_index = 0, resp_valid at cycle 17; count stays 16.
4. Hold resp_ready = 0 for 5 cycles during a response -> resp_valid and resp_* stable, req_ready = 0 throughout; IDLE one cycle after resp_ready = 1.
5. Assert rst_n = 0 mid-SEARCH after 3 allocations -> count = 1, resp_valid = 0, req_ready = 1; rd_addr = 1 gives rd_data = 0 next cycle.
6. (PC_LUT_ALLOC_FLUSH_EN) Allocate 72 and 87, then pulse flush together with req_valid in IDLE:
   - count = 1 and req_ready = 0 that cycle
   - a subsequent request for 87 returns index 1 with hit = 0
